cbfp_shift_detect: RTL
======================

Name: cbfp_shift_detect

Overview:
Front end of the CBFP1 normalisation path. It collects a streaming FFT butterfly output (R/Q of the add and sub branches, one sample per lane per cycle) into BLOCK_SIZE-sample blocks. For each branch it finds the block-wide minimum count of redundant sign bits. It then presents the captured block in parallel, together with shift_value_add and shift_value_sub, to the CBFP1 bit-shift stage. Input and output registers form a double buffer, so streaming continues without stalls.

Parameters:
INPUT_WIDTH, 25, signed sample width on every lane.
BLOCK_SIZE, 8, samples per block; must be a power of two, at least 2.
SHIFT_WIDTH, 5, width of each shift value; must hold INPUT_WIDTH-1.

Ports:
clk  in  1  clock; all logic on the rising edge.
rstn  in  1  asynchronous active-low reset.
clear  in  1  synchronous abort of the partially filled block.
in_valid  in  1  the lane samples are valid this cycle.
in_R_add, in_Q_add, in_R_sub, in_Q_sub  in  INPUT_WIDTH each  signed samples.
out_valid  out  1  single-cycle pulse; a block and its shift values are valid.
shift_value_add  out  SHIFT_WIDTH  minimum redundant sign bits over R_add and Q_add of the block.
shift_value_sub  out  SHIFT_WIDTH  the same over R_sub and Q_sub.
out_R_add, out_Q_add, out_R_sub, out_Q_sub  out  INPUT_WIDTH x [0:BLOCK_SIZE-1]  captured block; index 0 is the first sample.
blk_cnt  out  $clog2(BLOCK_SIZE)  fill index of the current block (debug and verification).

Behaviour:
- Reset (rstn=0, asynchronous): blk_cnt=0, out_valid=0, shift values=0, all out_* array entries=0, fill buffer=0, running minima=INPUT_WIDTH-1.
- Redundant sign count rsc(x): the number of bits below the MSB, starting at bit INPUT_WIDTH-2, that equal the sign bit, counted until the first mismatch. Range 0..INPUT_WIDTH-1.
  - rsc(0) = rsc(-1) = 24; rsc(1) = 23; rsc(4095) = 12; rsc(-4096) = 12; rsc(-2^24) = 0; rsc(2^24-1) = 0.
- Fill, on each cycle with in_valid=1 and clear=0:
  - write the four samples into the fill buffer at index blk_cnt;
  - min_add <= min(min_add, rsc(R_add), rsc(Q_add)); min_sub is updated the same way from the sub lanes;
  - blk_cnt increments and wraps from BLOCK_SIZE-1 to 0.
- Block complete: the accepted sample has blk_cnt=BLOCK_SIZE-1. On that same edge:
  - the output arrays load the fill buffer with the current sample merged at the last index;
  - the shift values load the final minima, including the current sample;
  - out_valid=1 on the next cycle only;
  - the running minima reload to INPUT_WIDTH-1.
- Latency: last sample of a block at edge t -> out_valid high for cycle t..t+1. Outputs then hold until the next block completes.
- in_valid gaps: no state change; blk_cnt, buffer and minima hold; out_valid stays 0.
- Back-to-back blocks: continuous in_valid gives out_valid once every BLOCK_SIZE cycles. The next block's first sample may arrive on the same edge as the completion; it goes to fill index 0.
- No backpressure. The consumer must sample the outputs while they hold, i.e. within BLOCK_SIZE cycles.
- clear=1: blk_cnt<=0 and the minima reset; the partial block is discarded.
  - clear has priority over an in_valid on the same cycle; that sample is dropped.
  - A completion on the same edge as clear is also dropped: no out_valid.
  - Already-presented outputs and shift values are unaffected.
- Reset mid-block: all state returns to the reset values; no out_valid for the partial block.
- Add and sub minima are independent. One saturated branch (rsc=0) does not affect the other.

Decomposition:
- Package cbfp_pkg:
  - localparams CBFP_IN_W=25, CBFP_OUT_W=12, CBFP_BLK=8, CBFP_SHIFT_W=5, CBFP_SHIFT_TARGET=13;
  - typedef cbfp_sample_t (signed CBFP_IN_W) and cbfp_shift_t.
- Sub-module cbfp_sign_count: combinational rsc for one sample. Instantiated 4 times (one per lane).
- The top holds the counter, fill buffer, output registers and min-compare logic.

Test Plan:
1. Reset, then 8 valid cycles with all lanes=1 -> one out_valid pulse 1 cycle after the 8th edge; shift_add=shift_sub=23; arrays all 1.
2. Add lanes with one sample R_add[3]=4095, rest 0; sub lanes with Q_sub[7]=-2^24, rest 0 -> shift_add=12, shift_sub=0; out_R_add[3]=4095.
3. 24 continuous valid cycles with ramp data k (1..24) -> 3 pulses, 8 cycles apart; the 3rd block has index 0=17, index 7=24; shift_add=rsc(24)=19.
4. 4 valid samples, in_valid gap of 5 cycles, 4 more -> exactly one pulse after the 8th sample; blk_cnt holds 4 during the gap.
5. 5 samples, then clear together with in_valid, then 8 samples with value -1 -> one pulse only; shift=24; arrays all -1; the pre-clear data is absent.
6. rstn low at blk_cnt=6, then release -> blk_cnt=0, out_valid=0, outputs 0; the next full block is reported normally.

Source files
------------

// File: rtl/cbfp_shift_detect_pkg.sv
// Shared definitions for the CBFP1 normalisation path.
// Contents: default block geometry, sample/shift widths and the sample and
// shift-value types used across the CBFP front end.
package cbfp_pkg;

    localparam int CBFP_IN_W         = 25;  // butterfly output sample width
    localparam int CBFP_OUT_W        = 12;  // width after CBFP1 bit shift
    localparam int CBFP_BLK          = 8;   // samples per normalisation block
    localparam int CBFP_SHIFT_W      = 5;   // holds 0..CBFP_IN_W-1
    localparam int CBFP_SHIFT_TARGET = 13;  // shift that maps CBFP_IN_W onto CBFP_OUT_W

    typedef logic signed [CBFP_IN_W-1:0] cbfp_sample_t;
    typedef logic [CBFP_SHIFT_W-1:0]     cbfp_shift_t;

endpackage

// File: rtl/cbfp_shift_detect_if.sv
// Streaming butterfly-to-CBFP bus.
// master: producer side; drives clear, in_valid and the four input lanes,
//         observes the captured block, shift values and fill index.
// slave:  cbfp_shift_detect; the reverse directions.
// Output arrays are indexed [0:BLOCK_SIZE-1], index 0 is the first sample.
interface cbfp_shift_detect_if
    import cbfp_pkg::*;
#(
    parameter int INPUT_WIDTH = CBFP_IN_W,
    parameter int BLOCK_SIZE  = CBFP_BLK,
    parameter int SHIFT_WIDTH = CBFP_SHIFT_W
) ();
    localparam int CNT_W = $clog2(BLOCK_SIZE);

    logic                          clear;
    logic                          in_valid;
    logic signed [INPUT_WIDTH-1:0] in_R_add;
    logic signed [INPUT_WIDTH-1:0] in_Q_add;
    logic signed [INPUT_WIDTH-1:0] in_R_sub;
    logic signed [INPUT_WIDTH-1:0] in_Q_sub;

    logic                          out_valid;
    logic [SHIFT_WIDTH-1:0]        shift_value_add;
    logic [SHIFT_WIDTH-1:0]        shift_value_sub;
    logic signed [INPUT_WIDTH-1:0] out_R_add [0:BLOCK_SIZE-1];
    logic signed [INPUT_WIDTH-1:0] out_Q_add [0:BLOCK_SIZE-1];
    logic signed [INPUT_WIDTH-1:0] out_R_sub [0:BLOCK_SIZE-1];
    logic signed [INPUT_WIDTH-1:0] out_Q_sub [0:BLOCK_SIZE-1];
    logic [CNT_W-1:0]              blk_cnt;

    modport master (
        output clear, in_valid, in_R_add, in_Q_add, in_R_sub, in_Q_sub,
        input  out_valid, shift_value_add, shift_value_sub,
               out_R_add, out_Q_add, out_R_sub, out_Q_sub, blk_cnt
    );

    modport slave (
        input  clear, in_valid, in_R_add, in_Q_add, in_R_sub, in_Q_sub,
        output out_valid, shift_value_add, shift_value_sub,
               out_R_add, out_Q_add, out_R_sub, out_Q_sub, blk_cnt
    );

endinterface

// File: rtl/cbfp_shift_detect_sign_count.sv
// cbfp_sign_count: combinational redundant-sign-bit count of one sample.
// Ports: sample (signed INPUT_WIDTH) in, rsc (SHIFT_WIDTH) out.
// rsc counts bits from INPUT_WIDTH-2 downward that equal the sign bit,
// stopping at the first mismatch; range 0..INPUT_WIDTH-1.
module cbfp_sign_count
    import cbfp_pkg::*;
#(
    parameter int INPUT_WIDTH = CBFP_IN_W,
    parameter int SHIFT_WIDTH = CBFP_SHIFT_W
) (
    input  logic signed [INPUT_WIDTH-1:0] sample,
    output logic [SHIFT_WIDTH-1:0]        rsc
);

    always_comb begin
        logic                   done;
        logic [SHIFT_WIDTH-1:0] cnt;
        // NOTE: every variable gets a value before the loop so no path leaves it unassigned (no latch).
        done = 1'b0;
        cnt  = '0;
        for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
            if (!done && (sample[i] == sample[INPUT_WIDTH-1])) begin
                cnt = cnt + SHIFT_WIDTH'(1);
            end else begin
                done = 1'b1;
            end
        end
        rsc = cnt;
    end

endmodule

// File: rtl/cbfp_shift_detect.sv
// cbfp_shift_detect: CBFP1 front end. Collects BLOCK_SIZE butterfly samples
// per lane, tracks the block-wide minimum redundant sign count of the add
// and sub branches, and presents the completed block in parallel with
// shift_value_add / shift_value_sub and a one-cycle out_valid pulse.
// Ports: clk, rstn (async active-low), bus (cbfp_shift_detect_if.slave):
//   clear, in_valid, in_{R,Q}_{add,sub} in;
//   out_valid, shift_value_{add,sub}, out_{R,Q}_{add,sub}[], blk_cnt out.
// The fill buffer and output registers form a double buffer: the block is
// copied out on the completing edge while the next block starts filling.
module cbfp_shift_detect
    import cbfp_pkg::*;
#(
    parameter int INPUT_WIDTH = CBFP_IN_W,
    parameter int BLOCK_SIZE  = CBFP_BLK,
    parameter int SHIFT_WIDTH = CBFP_SHIFT_W
) (
    input logic               clk,
    input logic               rstn,
    cbfp_shift_detect_if.slave bus
);

    localparam int                     CNT_W    = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [SHIFT_WIDTH-1:0] MIN_INIT = SHIFT_WIDTH'(INPUT_WIDTH - 1);

    typedef logic signed [INPUT_WIDTH-1:0] sample_t;
    typedef struct packed {
        sample_t r_add;
        sample_t q_add;
        sample_t r_sub;
        sample_t q_sub;
    } lanes_t;

    function automatic logic [SHIFT_WIDTH-1:0] min3(input logic [SHIFT_WIDTH-1:0] a,
                                                    input logic [SHIFT_WIDTH-1:0] b,
                                                    input logic [SHIFT_WIDTH-1:0] c);
        logic [SHIFT_WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    lanes_t                 fill [BLOCK_SIZE];
    lanes_t                 cur;
    logic [CNT_W-1:0]       blk_cnt;
    logic [SHIFT_WIDTH-1:0] min_add, min_sub;
    logic [SHIFT_WIDTH-1:0] rsc_r_add, rsc_q_add, rsc_r_sub, rsc_q_sub;
    logic [SHIFT_WIDTH-1:0] next_min_add, next_min_sub;

    assign cur = '{r_add: bus.in_R_add, q_add: bus.in_Q_add,
                   r_sub: bus.in_R_sub, q_sub: bus.in_Q_sub};

    cbfp_sign_count #(.INPUT_WIDTH(INPUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH))
        u_rsc_r_add (.sample(bus.in_R_add), .rsc(rsc_r_add));
    cbfp_sign_count #(.INPUT_WIDTH(INPUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH))
        u_rsc_q_add (.sample(bus.in_Q_add), .rsc(rsc_q_add));
    cbfp_sign_count #(.INPUT_WIDTH(INPUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH))
        u_rsc_r_sub (.sample(bus.in_R_sub), .rsc(rsc_r_sub));
    cbfp_sign_count #(.INPUT_WIDTH(INPUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH))
        u_rsc_q_sub (.sample(bus.in_Q_sub), .rsc(rsc_q_sub));

    // Minima including the sample on the inputs; used both for the running
    // update and for the final shift value on the completing edge.
    assign next_min_add = min3(min_add, rsc_r_add, rsc_q_add);
    assign next_min_sub = min3(min_sub, rsc_r_sub, rsc_q_sub);

    assign bus.blk_cnt = blk_cnt;

    // NOTE: all state here uses <= so every read sees the pre-edge value; the
    // output copy below relies on this to read fill[] before this edge's write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt             <= '0;
            min_add             <= MIN_INIT;
            min_sub             <= MIN_INIT;
            bus.out_valid       <= 1'b0;
            bus.shift_value_add <= '0;
            bus.shift_value_sub <= '0;
            // NOTE: the buffers are register arrays with a defined reset value,
            // so they are cleared here; this keeps them out of RAM inference.
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                fill[i]          <= '0;
                bus.out_R_add[i] <= '0;
                bus.out_Q_add[i] <= '0;
                bus.out_R_sub[i] <= '0;
                bus.out_Q_sub[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.clear) begin
                // Discard the partial block; a sample or completion on this edge is dropped.
                blk_cnt <= '0;
                min_add <= MIN_INIT;
                min_sub <= MIN_INIT;
            end else if (bus.in_valid) begin
                fill[blk_cnt] <= cur;
                blk_cnt       <= blk_cnt + CNT_W'(1);  // power-of-two size wraps naturally
                if (blk_cnt == LAST_IDX) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        bus.out_R_add[i] <= (i == BLOCK_SIZE - 1) ? cur.r_add : fill[i].r_add;
                        bus.out_Q_add[i] <= (i == BLOCK_SIZE - 1) ? cur.q_add : fill[i].q_add;
                        bus.out_R_sub[i] <= (i == BLOCK_SIZE - 1) ? cur.r_sub : fill[i].r_sub;
                        bus.out_Q_sub[i] <= (i == BLOCK_SIZE - 1) ? cur.q_sub : fill[i].q_sub;
                    end
                    bus.shift_value_add <= next_min_add;
                    bus.shift_value_sub <= next_min_sub;
                    bus.out_valid       <= 1'b1;
                    min_add             <= MIN_INIT;
                    min_sub             <= MIN_INIT;
                end else begin
                    min_add <= next_min_add;
                    min_sub <= next_min_sub;
                end
            end
        end
    end

endmodule
